fibonacci_arbiter: RTL and testbench
====================================

# fibonacci_arbiter

Shares one Fibonacci engine between two requesters. Each requester asks for F(n), where F(1)=F(2)=1, matching the sequence convention of the existing `fibonacci` / `fibonacci_2` generators. The block round-robin arbitrates requests and steps an internal double-rate engine, two indices per cycle, from the seed. It returns the 16-bit result with a requester ID over a valid/ready response channel. It sits in the sequential-basics set as the controller/scheduler layer above the free-running generators.

## Interface
- `N_W`, default 5: width of the requested index n.
- `MAX_N`, default 24: largest legal index. F(24)=46368 is the last value that fits in 16 bits.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `req0_valid`  in  1: requester 0 has a request.
- `req0_n`  in  N_W: index requested by requester 0.
- `req0_ready`  out  1: requester 0 request accepted this cycle when `req0_valid` is also high.
- `req1_valid`, `req1_n`, `req1_ready`: same as requester 0, for requester 1.
- `rsp_valid`  out  1: response available.
- `rsp_ready`  in  1: consumer accepts response.
- `rsp_id`  out  1: requester the response belongs to.
- `rsp_num`  out  16: F(n).
- `rsp_err`  out  1: n illegal (n==0 or n>MAX_N).
- `busy`  out  1: high whenever the FSM is not in IDLE.

## Operation
- FSM states:
  - IDLE: accepts one request. Legal n goes to RUN; illegal n goes to RESP.
  - RUN: steps the engine. Goes to RESP when done.
  - RESP: holds the response. Goes to IDLE on `rsp_valid && rsp_ready`.
- Arbitration:
  - In IDLE, grant = requester with valid high.
  - If both are valid, grant the one not served last. Pointer `last` resets to 1, so req0 wins the first tie.
  - `last` updates only on accept.
- Ready signals:
  - `reqX_ready` = (state==IDLE) && grant==X. Combinational from state and valids.
  - Never both high. Both low outside IDLE.
- Captured at accept: n, id.
- Engine registers: a=F(k), b=F(k+1), counter k. On accept: a=1, b=1, k=1.
- RUN each cycle:
  - If n−k ≤ 1: `rsp_num` ← (n==k ? a : b), go to RESP.
  - Else: a ← a+b, b ← a+(b<<1), k ← k+2.
- Arithmetic is 16-bit modulo. Overflow cannot occur for n ≤ MAX_N=24. Larger MAX_N is unsupported.
- Illegal n: `rsp_err`=1, `rsp_num`=0, no RUN cycles.
- RESP: `rsp_valid`, `rsp_id`, `rsp_num`, `rsp_err` are registered and held stable until the handshake. No new request is accepted until IDLE.
- Reset:
  - Asserting `rst` at any time, including mid-RUN or mid-RESP, immediately forces IDLE and `last`=1.
  - All outputs go to 0, except the `reqX_ready` signals, which follow IDLE rules.
  - The in-flight request is dropped; no response is ever produced for it.

## Timing
- Accept edge = E.
  - Legal n: `rsp_valid` rises after edge E+1+floor((n−1)/2).
  - n=1 or n=2: E+1. n=10: E+5. n=24: E+12.
  - Illegal n: `rsp_valid` rises after edge E+1.
- Response handshake at edge H: `rsp_valid` low after H. The earliest next accept is at edge H+1; there is no same-cycle turnaround.
- Reset values: `rsp_valid`=0, `rsp_id`=0, `rsp_num`=0, `rsp_err`=0, `busy`=0, state IDLE.

## Configuration
- Macro `FIB_ARBITER_DOUBLE_RATE_EN`.
- Defined: double-rate engine as described above. Latency is E+1+floor((n−1)/2).
- Undefined: single-rate engine.
  - Each RUN cycle: if k==n, `rsp_num` ← a and go to RESP; else a ← b, b ← a+b, k ← k+1.
  - Latency: `rsp_valid` rises after edge E+n (n=10: E+10).
- Results, handshakes and arbitration are identical in both builds.

## Test plan
- req0 n=10 alone, `rsp_ready`=1 → `rsp_num`=55, `rsp_id`=0, `rsp_err`=0, `rsp_valid` high for one cycle after edge E+5 (E+10 without the macro).
- req0 n=24 and req1 n=1 both valid from reset → req0 served first (46368), then req1 (1). Next tie with both valid → req1 granted first.
- n=0, then n=25 → `rsp_err`=1, `rsp_num`=0, `rsp_valid` after E+1, no RUN cycles.
- n=7 with `rsp_ready` low for 5 cycles → `rsp_num`=13 held stable, `busy`=1, both `reqX_ready` low; IDLE entered the edge after `rsp_ready` goes high.
- `rst` pulsed between clock edges mid-RUN for n=20 → outputs 0 without waiting for a clock edge; no response ever appears for that request. A following request n=20 returns 6765.
- n=1 and n=2 back-to-back on req1 → both return 1, each after E+1.

Source files
------------

// File: rtl/fibonacci_arbiter.sv
// Two-requester round-robin front end sharing one Fibonacci engine, F(1)=F(2)=1.
// Build option FIB_ARBITER_DOUBLE_RATE_EN: defined = two indices per cycle, undefined = one per cycle.
// Latency after accept edge E: E+1+floor((n-1)/2) (double) or E+n (single); no new accept until the response handshakes.
module fibonacci_arbiter #(
    parameter int N_W   = 5,
    parameter int MAX_N = 24
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    input  logic [N_W-1:0] req0_n,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [N_W-1:0] req1_n,
    output logic           req1_ready,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [15:0]    rsp_num,
    output logic           rsp_err,
    output logic           busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [N_W-1:0] MAX_N_L = N_W'(MAX_N);
    localparam logic [N_W-1:0] ONE_L   = N_W'(1);

    state_t         r_state;
    logic           r_last;
    logic           r_id;
    logic           r_err;
    logic [N_W-1:0] r_n;
    logic [N_W-1:0] r_k;
    logic [15:0]    r_a;
    logic [15:0]    r_b;
    logic           r_rsp_valid;
    logic           r_rsp_id;
    logic [15:0]    r_rsp_num;
    logic           r_rsp_err;

    logic           w_idle;
    logic           w_gnt1;
    logic           w_acc;
    logic [N_W-1:0] w_n;
    logic           w_bad;

    // On a tie, requester 1 wins only if requester 0 was served last.
    assign w_idle     = (r_state == S_IDLE);
    assign w_gnt1     = req1_valid && (!req0_valid || !r_last);
    assign req0_ready = w_idle && req0_valid && !w_gnt1;
    assign req1_ready = w_idle && w_gnt1;
    assign w_acc      = req0_ready || req1_ready;
    assign w_n        = w_gnt1 ? req1_n : req0_n;
    assign w_bad      = (w_n == '0) || (w_n > MAX_N_L);

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_num    = r_rsp_num;
    assign rsp_err    = r_rsp_err;
    assign busy       = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last      <= 1'b1;
            r_id        <= 1'b0;
            r_err       <= 1'b0;
            r_n         <= '0;
            r_k         <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_num   <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_last  <= w_gnt1;
                        r_id    <= w_gnt1;
                        r_n     <= w_n;
                        r_err   <= w_bad;
                        r_a     <= 16'd1;
                        r_b     <= 16'd1;
                        r_k     <= ONE_L;
                        r_state <= w_bad ? S_RESP : S_RUN;
                    end
                end
                S_RUN: begin
`ifdef FIB_ARBITER_DOUBLE_RATE_EN
                    // a=F(k), b=F(k+1); k never passes n, so n-k cannot wrap.
                    if ((r_n - r_k) <= ONE_L) begin
                        r_rsp_num   <= (r_n == r_k) ? r_a : r_b;
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_id;
                        r_rsp_err   <= 1'b0;
                        r_state     <= S_RESP;
                    end else begin
                        r_a <= r_a + r_b;
                        r_b <= r_a + (r_b << 1);
                        r_k <= r_k + N_W'(2);
                    end
`else
                    if (r_n == r_k) begin
                        r_rsp_num   <= r_a;
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_id;
                        r_rsp_err   <= 1'b0;
                        r_state     <= S_RESP;
                    end else begin
                        r_a <= r_b;
                        r_b <= r_a + r_b;
                        r_k <= r_k + ONE_L;
                    end
`endif
                end
                S_RESP: begin
                    // Error requests arrive here with valid still low; present them one cycle later.
                    if (!r_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_id;
                        r_rsp_err   <= r_err;
                        r_rsp_num   <= '0;
                    end else if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fibonacci_arbiter.sv
// Scoreboard bench for fibonacci_arbiter: directed scenarios followed by random traffic.
`timescale 1ns/1ps
module tb_fibonacci_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0;
    logic [4:0]  req0_n = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [4:0]  req1_n = '0;
    logic        req1_ready;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_id;
    logic [15:0] rsp_num;
    logic        rsp_err;
    logic        busy;

    fibonacci_arbiter #(.N_W(5), .MAX_N(24)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_n(req0_n), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_n(req1_n), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_num(rsp_num), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          id;
        logic [15:0] num;
        bit          err;
        int          rise;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_hs = 0;
    int   n_hs_seen = 0;
    bit   m_idle = 1'b1;
    bit   m_last = 1'b1;
    bit   want0 = 1'b0;
    bit   want1 = 1'b0;
    int   wn0 = 0;
    int   wn1 = 0;
    bit   rr = 1'b1;
    bit   prev_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int fib(input int n);
        int a = 1;
        int b = 1;
        int t;
        for (int i = 2; i <= n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic bit illegal(input int n);
        return (n == 0) || (n > 24);
    endfunction

    function automatic int lat(input int n);
        if (illegal(n)) return 1;
`ifdef FIB_ARBITER_DOUBLE_RATE_EN
        return 1 + (n - 1) / 2;
`else
        return n;
`endif
    endfunction

    // One clock of stimulus: drive at negedge+1, check handshake-side signals at negedge+2.
    task automatic step();
        bit g;
        bit e0;
        bit e1;
        int n;
        exp_t e;
        @(negedge clk);
        #1;
        if (n_hs != n_hs_seen) begin
            m_idle    = 1'b1;
            n_hs_seen = n_hs;
        end
        req0_valid = want0;
        req0_n     = 5'(wn0);
        req1_valid = want1;
        req1_n     = 5'(wn1);
        rsp_ready  = rr;
        #1;
        g  = (want0 && want1) ? !m_last : want1;
        e0 = m_idle && want0 && !g;
        e1 = m_idle && want1 && g;
        chk("req0_ready", 32'(req0_ready), 32'(e0));
        chk("req1_ready", 32'(req1_ready), 32'(e1));
        chk("busy", 32'(busy), 32'(!m_idle));
        if (e0 || e1) begin
            n      = g ? wn1 : wn0;
            e.id   = g;
            e.err  = illegal(n);
            e.num  = e.err ? 16'd0 : 16'(fib(n));
            e.rise = cyc + 1 + lat(n);
            q.push_back(e);
            m_last = g;
            m_idle = 1'b0;
            if (g) want1 = 1'b0;
            else   want0 = 1'b0;
        end
    endtask

    task automatic drain();
        int i = 0;
        while ((want0 || want1 || !m_idle || q.size() != 0) && i < 400) begin
            step();
            i++;
        end
        total++;
        if (want0 || want1 || !m_idle || q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: pending=%0d required=0", q.size());
        end
    endtask

    task automatic wait_accept();
        int i = 0;
        while ((want0 || want1) && i < 100) begin
            step();
            i++;
        end
        total++;
        if (want0 || want1) begin
            bad++;
            $display("FAIL accept_timeout: waiting=%0d required=0", 32'(want0) + 32'(want1));
        end
    endtask

    // Reset pulse lands between clock edges; outputs must clear without an edge.
    task automatic pulse_reset();
        step();
        rst = 1'b1;
        #0.5;
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_num", 32'(rsp_num), 0);
        chk("rst_err", 32'(rsp_err), 0);
        rst = 1'b0;
        q.delete();
        m_idle = 1'b1;
        m_last = 1'b1;
        n_hs_seen = n_hs;
    endtask

    // Monitor: runs after the driver each cycle; a handshake here completes on the next edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: id=%0d num=%0d required=no response", rsp_id, rsp_num);
                end else begin
                    e = q[0];
                    if (!prev_v) chk("rise_cycle", 32'(cyc), 32'(e.rise));
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_num", 32'(rsp_num), 32'(e.num));
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        n_hs++;
                    end
                end
            end
            prev_v = rsp_valid;
        end
    end

    initial begin
        #1;
        chk("reset_async_valid", 32'(rsp_valid), 0);
        chk("reset_async_busy", 32'(busy), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_id", 32'(rsp_id), 0);
        chk("reset_num", 32'(rsp_num), 0);
        chk("reset_err", 32'(rsp_err), 0);

        // single request, n=10
        rr = 1'b1;
        want0 = 1'b1; wn0 = 10;
        drain();

        // tie from reset, then a fresh tie while req1 is still waiting
        pulse_reset();
        want0 = 1'b1; wn0 = 24;
        want1 = 1'b1; wn1 = 1;
        wait_accept_first: begin
            int i = 0;
            while (want0 && i < 20) begin step(); i++; end
        end
        want0 = 1'b1; wn0 = 3;
        drain();

        // illegal indices back-to-back
        want0 = 1'b1; wn0 = 0;
        wait_accept();
        want0 = 1'b1; wn0 = 25;
        drain();

        // consumer stall with a competing request pending
        rr = 1'b0;
        want0 = 1'b1; wn0 = 7;
        wait_accept();
        want1 = 1'b1; wn1 = 5;
        repeat (lat(7) + 5) step();
        rr = 1'b1;
        drain();

        // reset in the middle of a long computation
        want0 = 1'b1; wn0 = 20;
        wait_accept();
        repeat (4) step();
        pulse_reset();
        repeat (25) step();
        want0 = 1'b1; wn0 = 20;
        drain();

        // n=1 then n=2 on requester 1
        want1 = 1'b1; wn1 = 1;
        wait_accept();
        want1 = 1'b1; wn1 = 2;
        drain();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            rr = ($urandom_range(0, 3) != 0);
            if (!want0 && $urandom_range(0, 2) == 0) begin
                want0 = 1'b1;
                wn0 = $urandom_range(0, 31);
            end
            if (!want1 && $urandom_range(0, 2) == 0) begin
                want1 = 1'b1;
                wn1 = $urandom_range(0, 31);
            end
            step();
        end
        rr = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
